// File: rtl/reaction_timer_ctrl_if.sv
// Player/light-sequence side signals of the reaction timer.
// The slave modport is the controller; the master modport drives btn/lights.
interface reaction_timer_ctrl_if #(
  parameter int D_WIDTH = 8,
  parameter int T_WIDTH = 12
);
  logic               btn;
  logic [D_WIDTH-1:0] lights;
  logic               seq_trigger;
  logic               busy;
  logic               result_vld;
  logic               jump_start;
  logic               timeout;
  logic [T_WIDTH-1:0] react_ms;
  logic [T_WIDTH-1:0] best_ms;

  modport slave (
    input  btn, lights,
    output seq_trigger, busy, result_vld, jump_start, timeout, react_ms, best_ms
  );

  modport master (
    output btn, lights,
    input  seq_trigger, busy, result_vld, jump_start, timeout, react_ms, best_ms
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// F1 start-light session controller: triggers the light sequence, times lights-out
// to button press in ms ticks, flags jump starts/timeouts, keeps last and best times.
module reaction_timer_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int T_WIDTH = 12,
  parameter int DIV     = 1000,
  parameter int MAX_MS  = 2000
) (
  input logic                  clk,
  input logic                  rst,
  reaction_timer_ctrl_if.slave bus
);
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, ARM, LIT, TIMING, FOUL, RESULT} state_t;

  state_t             state;
  logic [PW-1:0]      pre;
  logic [T_WIDTH-1:0] cnt;
  logic               btn_s1, btn_s2, btn_d;
  logic               press;
  logic               seq_trigger, busy, result_vld, jump_start, timeout;
  logic [T_WIDTH-1:0] react_ms, best_ms;

  // btn is asynchronous: two flops to resolve metastability, a third for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      btn_s1 <= bus.btn;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pre         <= '0;
      cnt         <= '0;
      seq_trigger <= 1'b0;
      busy        <= 1'b0;
      result_vld  <= 1'b0;
      jump_start  <= 1'b0;
      timeout     <= 1'b0;
      react_ms    <= '0;
      best_ms     <= '1;
    end else begin
      seq_trigger <= 1'b0;
      result_vld  <= 1'b0;
      case (state)
        IDLE, RESULT: begin
          if (press) begin
            state       <= ARM;
            seq_trigger <= 1'b1;
            busy        <= 1'b1;
            jump_start  <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        ARM: begin
          if (press)                             state <= FOUL;
          else if (bus.lights == {D_WIDTH{1'b1}}) state <= LIT;
        end
        LIT: begin
          // A press coinciding with lights-out is still a jump start.
          if (press) state <= FOUL;
          else if (bus.lights == '0) begin
            state <= TIMING;
            pre   <= '0;
            cnt   <= '0;
          end
        end
        TIMING: begin
          // Press has priority over the timeout in the same cycle.
          if (press) begin
            state      <= RESULT;
            busy       <= 1'b0;
            result_vld <= 1'b1;
            react_ms   <= cnt;
            if (cnt < best_ms) best_ms <= cnt;
          end else if (cnt == T_WIDTH'(MAX_MS)) begin
            state   <= RESULT;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (pre == PW'(DIV - 1)) begin
            pre <= '0;
            cnt <= cnt + 1'b1;
          end else begin
            pre <= pre + 1'b1;
          end
        end
        FOUL: begin
          state      <= RESULT;
          busy       <= 1'b0;
          jump_start <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.seq_trigger = seq_trigger;
  assign bus.busy        = busy;
  assign bus.result_vld  = result_vld;
  assign bus.jump_start  = jump_start;
  assign bus.timeout     = timeout;
  assign bus.react_ms    = react_ms;
  assign bus.best_ms     = best_ms;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with DIV=4, MAX_MS=20.
module tb_reaction_timer_ctrl;
  localparam int D_WIDTH = 8;
  localparam int T_WIDTH = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   trig_cnt = 0;
  int   vld_cnt  = 0;
  int   tc, vc;

  always #5 clk = ~clk;

  reaction_timer_ctrl_if #(.D_WIDTH(D_WIDTH), .T_WIDTH(T_WIDTH)) bus ();

  reaction_timer_ctrl #(.D_WIDTH(D_WIDTH), .T_WIDTH(T_WIDTH), .DIV(4), .MAX_MS(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.seq_trigger) trig_cnt <= trig_cnt + 1;
    if (bus.result_vld)  vld_cnt  <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press lands on the third clock edge after btn rises; returns 1ns after an edge.
  task automatic tap();
    bus.btn = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic lights_up();
    logic [D_WIDTH-1:0] pat;
    for (int i = 1; i <= 8; i++) begin
      pat = D_WIDTH'((1 << i) - 1);
      bus.lights = pat;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  // Lights out, then btn rises n cycles later.
  task automatic react(input int n, input logic [31:0] exp_react, input logic [31:0] exp_best);
    bus.lights = '0;
    repeat (n) @(posedge clk);
    #1 bus.btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("result_vld_pulse", bus.result_vld, 1);
    check("react_ms", bus.react_ms, exp_react);
    check("best_ms", bus.best_ms, exp_best);
    check("busy_result", bus.busy, 0);
    @(posedge clk);
    #1;
    check("result_vld_1cyc", bus.result_vld, 0);
    bus.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.btn    = 1'b0;
    bus.lights = '0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_trig", bus.seq_trigger, 0);
    check("rst_best", bus.best_ms, 12'hFFF);
    check("rst_react", bus.react_ms, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: trigger pulse width
    bus.btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("trig_early", bus.seq_trigger, 0);
    @(posedge clk);
    #1 check("trig_high", bus.seq_trigger, 1);
    check("busy_arm", bus.busy, 1);
    @(posedge clk);
    #1 check("trig_low", bus.seq_trigger, 0);
    bus.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 2/3: valid reactions
    lights_up();
    react(4*7+2, 7, 7);
    tap();
    lights_up();
    react(4*10+2, 10, 7);
    tap();
    lights_up();
    react(4*3+2, 3, 3);
    check("trig_total", trig_cnt, 3);

    // 4a: press while all lights on
    vc = vld_cnt;
    tap();
    lights_up();
    tap();
    check("jump_flag", bus.jump_start, 1);
    check("jump_busy", bus.busy, 0);
    check("jump_react", bus.react_ms, 3);
    check("jump_best", bus.best_ms, 3);
    check("jump_no_vld", vld_cnt, vc);

    // 4b: press on the same cycle as lights-out
    tap();
    check("jump_cleared", bus.jump_start, 0);
    lights_up();
    bus.btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.lights = '0;
    repeat (3) @(posedge clk);
    #1 bus.btn = 1'b0;
    check("same_cyc_jump", bus.jump_start, 1);
    check("same_cyc_no_vld", vld_cnt, vc);
    repeat (3) @(posedge clk);
    #1;

    // 5: timeout after 20 ticks
    tap();
    check("jump_cleared2", bus.jump_start, 0);
    lights_up();
    bus.lights = '0;
    repeat (70) @(posedge clk);
    #1;
    check("to_pending", bus.timeout, 0);
    check("to_busy", bus.busy, 1);
    repeat (15) @(posedge clk);
    #1;
    check("to_flag", bus.timeout, 1);
    check("to_idle", bus.busy, 0);
    check("to_react", bus.react_ms, 3);
    check("to_no_vld", vld_cnt, vc);

    // 6: reset mid-TIMING, then a glitch between edges
    tap();
    check("to_cleared", bus.timeout, 0);
    lights_up();
    bus.lights = '0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_best", bus.best_ms, 12'hFFF);
    check("mid_rst_react", bus.react_ms, 0);
    tc = trig_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 bus.btn = 1'b1;
    #2 bus.btn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy", bus.busy, 0);
    check("glitch_no_trig", trig_cnt, tc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
